// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader that streams a length-prefixed, XOR-checked program
//            into instruction memory and holds the core in reset until done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            nlo_q, nlo_d;
    logic [15:0]           n_q, n_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            xor_q, xor_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  w_accept;
    logic [15:0]           w_n_new;

    assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign busy       = byte_ready;
    assign core_reset = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    assign w_accept = byte_valid && byte_ready;
    assign w_n_new  = {byte_data, nlo_q};

    always_comb begin
        state_d = state_q;
        nlo_d   = nlo_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (w_accept && state_q != S_CSUM) begin
            xor_d = xor_q ^ byte_data;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR0;
                    widx_d  = '0;
                    bidx_d  = 2'd0;
                    xor_d   = 8'h00;
                end
            end
            S_HDR0: begin
                if (w_accept) begin
                    nlo_d   = byte_data;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    n_d = w_n_new;
                    if (32'(w_n_new) > DEPTH) begin
                        state_d = S_ERR;
                    end else if (w_n_new == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_WIDTH-1:0];
                        wdata_d = {byte_data, asm_q};
                        bidx_d  = 2'd0;
                        widx_d  = widx_q + 1'b1;
                        // Last word: checksum byte may follow immediately.
                        if (16'(widx_q) == n_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        asm_d[8*bidx_q +: 8] = byte_data;
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    state_d = (byte_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            nlo_q   <= 8'h00;
            n_q     <= 16'h0000;
            widx_q  <= '0;
            bidx_q  <= 2'd0;
            asm_q   <= 24'h000000;
            xor_q   <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            nlo_q   <= nlo_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed scoreboard bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  byte_valid = 1'b0;
    logic [7:0]            byte_data = 8'h00;
    logic                  byte_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_reset;
    logic                  busy;
    logic                  done;
    logic                  error;

    int checks = 0;
    int errors = 0;

    logic [7:0]            stim[$];
    logic [ADDR_WIDTH-1:0] exp_addr[$];
    logic [31:0]           exp_data[$];

    imem_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", imem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic expect_write(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_stream(input bit gaps, input bit start_mid);
        for (int i = 0; i < stim.size(); i++) begin
            bit acc;
            int n;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin @(posedge clk); #1; end
            end
            byte_valid = 1'b1;
            byte_data  = stim[i];
            if (start_mid && i == 5) start = 1'b1;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = byte_ready;
                @(posedge clk);
                n++;
            end
            if (!acc) chk("accept_timeout", 32'(n), 32'd0);
            #1;
            byte_valid = 1'b0;
            start      = 1'b0;
        end
    endtask

    task automatic check_outcome(input string tag, input logic d, input logic e);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_core_reset"}, 32'(core_reset), 32'(!d));
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic good_session(input bit gaps, input bit start_mid);
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        expect_write(8'd0, 32'h0000_0013);
        expect_write(8'd1, 32'h0010_0093);
        pulse_start();
        run_stream(gaps, start_mid);
    endtask

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        @(posedge clk); #1;

        pulse_start();
        @(negedge clk);
        chk("start_ready", 32'(byte_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;

        // Good load N=2, already in HDR0
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        expect_write(8'd0, 32'h0000_0013);
        expect_write(8'd1, 32'h0010_0093);
        run_stream(1'b0, 1'b0);
        check_outcome("good", 1'b1, 1'b0);
        chk("good_sb_empty", 32'(exp_addr.size()), 32'd0);

        // Bad checksum: writes still happen, then ERR
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
        expect_write(8'd0, 32'h0000_0013);
        expect_write(8'd1, 32'h0010_0093);
        pulse_start();
        run_stream(1'b0, 1'b0);
        check_outcome("badcs", 1'b0, 1'b1);
        chk("badcs_sb_empty", 32'(exp_addr.size()), 32'd0);

        good_session(1'b0, 1'b0);
        check_outcome("restart", 1'b1, 1'b0);

        // N = 0
        stim = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        run_stream(1'b0, 1'b0);
        check_outcome("n0", 1'b1, 1'b0);

        // N = 257 exceeds depth
        stim = '{8'h01, 8'h01};
        pulse_start();
        run_stream(1'b0, 1'b0);
        check_outcome("nbig", 1'b0, 1'b1);
        @(negedge clk);
        chk("nbig_ready_later", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;

        // Random gaps plus start inside DATA
        good_session(1'b1, 1'b1);
        check_outcome("gaps", 1'b1, 1'b0);
        chk("gaps_sb_empty", 32'(exp_addr.size()), 32'd0);

        // Reset after five accepted bytes
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        pulse_start();
        run_stream(1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        @(posedge clk); #1;

        good_session(1'b0, 1'b0);
        check_outcome("fresh", 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(exp_addr.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the instruction memory read by the single-cycle core. It takes a byte stream over a valid/ready handshake, checks a length header, assembles little-endian 32-bit words and writes them to consecutive word addresses. It verifies a trailing XOR checksum. It holds the core in reset from power-up until a load completes with a good checksum.

## Interface
Parameters:
- ADDR_WIDTH, 8: instruction-memory word-address width. DEPTH = 2**ADDR_WIDTH words.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a load session; sampled only in IDLE, DONE or ERR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  word to write.
- core_reset  out  1  hold the datapath PC/register state in reset.
- busy  out  1  session in progress.
- done  out  1  last session succeeded.
- error  out  1  last session failed.

## Operation
- A byte is accepted when byte_valid && byte_ready.
- byte_ready is decoded from state only and never depends on byte_valid. It is 1 in HDR0, HDR1, DATA and CSUM, and 0 in all other states.
- Stream format: N_lo, N_hi, then N×4 payload bytes (each word little-endian, word 0 first), then one checksum byte.
- The checksum byte equals the XOR of all preceding bytes, header included.

States:
- IDLE: core_reset=1. start → HDR0.
- HDR0: accept N_lo → HDR1.
- HDR1: accept N_hi. N = {N_hi, N_lo}, 16 bits.
  - N > DEPTH → ERR.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA: 2-bit byte index; byte k goes into bits [8k+7:8k]. On the 4th byte:
  - register imem_wdata = assembled word and imem_addr = word index;
  - pulse imem_we;
  - clear the byte index and increment the word index.
  - When the word just written is word N-1 → CSUM.
- CSUM: accept the checksum byte. Match with running XOR → DONE; mismatch → ERR.
- DONE: done=1, core_reset=0, busy=0. start → HDR0.
- ERR: error=1, core_reset=1, busy=0. start → HDR0.

Session start and flags:
- Entering HDR0 clears the word index, byte index and running XOR, and drops done and error.
- core_reset=1 and busy=1 in HDR0, HDR1, DATA and CSUM.
- start in HDR0, HDR1, DATA or CSUM is ignored.
- Words written before an error are not rolled back. The core stays in reset, so they are harmless.
- Word index width is ADDR_WIDTH+1 so that N == DEPTH loads every address with no wrap.

## Timing
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, busy 0, done 0, error 0.
- Reset mid-session returns to IDLE on the next edge. Reset has priority over every other input.
- start in IDLE on cycle t puts byte_ready=1 and busy=1 at cycle t+1.
- Throughput is one byte per cycle. Gaps in byte_valid stall the FSM with no other effect.
- imem_we is high for exactly the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are valid in that cycle and hold until the next write.
- DONE or ERR is entered one cycle after the deciding byte is accepted. In that same cycle byte_ready falls and done or error rises. On DONE, core_reset falls in that same cycle.
- On the last word, imem_we and the CSUM state share a cycle. The checksum byte may be accepted in that cycle.

## Test plan
- Reset: assert reset for 2 cycles → core_reset=1, byte_ready=0, done=error=busy=imem_we=0. Pulse start → byte_ready=1 on the next cycle.
- Good load, N=2, stream 02 00 13 00 00 00 93 00 10 00 92 sent back-to-back → imem_we pulses with (addr 0, 0x00000013), then (addr 1, 0x00100093). done=1 and core_reset=0 one cycle after 0x92 is accepted.
- Same stream with checksum 0x93 → both writes occur, error=1, done=0, core_reset stays 1. Then a restart with the correct stream → done=1.
- N=0, stream 00 00 00 → no imem_we, done=1. With ADDR_WIDTH=8 and header 01 01 (N=257) → ERR one cycle after the 2nd byte, and byte_ready=0 thereafter.
- Random byte_valid gaps over the good N=2 stream, plus a start pulse while in DATA → identical writes and result; start is ignored.
- Reset asserted after 5 accepted bytes → IDLE, core_reset=1, busy=0. A fresh full session then succeeds.
